lcd_frame_capture: RTL and testbench

//  Consumes the gameboy LCD pixel stream (pixel_data/pixel_clock/hsync/vsync) and packs it
//  4 pixels/byte into a double-buffered framebuffer RAM (async_mem-style write port).

---
 rtl/lcd_frame_capture_if.sv | 13 +
 rtl/lcd_frame_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_frame_capture.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_capture_if.sv
// Framebuffer write port between the LCD capture block and the
// double-buffered frame RAM (async_mem-style: one write strobe per byte).
interface lcd_frame_capture_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] fb_addr;  // byte address within the bank
    logic [7:0]        fb_data;  // 4 packed pixels, first pixel in [7:6]
    logic              fb_we;    // single-cycle write strobe
    logic              fb_bank;  // bank being written

    modport master (output fb_addr, fb_data, fb_we, fb_bank);
    modport slave  (input  fb_addr, fb_data, fb_we, fb_bank);
endinterface

// File: rtl/lcd_frame_capture.sv
// LCD frame capture: samples the gameboy pixel stream, packs 4 pixels per
// byte and writes completed bytes into the active framebuffer bank. The
// other bank always holds the last complete frame.
module lcd_frame_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 13
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                capture_en,
    input  logic [1:0]          pixel_data,
    input  logic                pixel_clock,
    input  logic                hsync,
    input  logic                vsync,
    lcd_frame_capture_if.master fb,
    output logic                frame_done,
    output logic [7:0]          frame_count,
    output logic                line_err,
    output logic                frame_err
);
    localparam int                LINE_BYTES = H_PIXELS / 4;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(V_LINES * LINE_BYTES - 1);
    localparam logic [7:0]        X_END      = 8'(H_PIXELS);
    localparam logic [7:0]        Y_END      = 8'(V_LINES);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic              pclk_q, hs_q, vs_q;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        sh_q, sh_d;        // last up to 3 pixels of the open group
    logic              we_q, we_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              bank_q;
    logic              toggle_q, toggle_d;
    logic              done_q, done_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              lerr_q, lerr_d;
    logic              ferr_q, ferr_d;

    logic              pclk_rise, hs_rise, vs_rise;
    logic              pix_ok;
    logic [7:0]        byte_full;
    logic [7:0]        x1;
    logic [5:0]        sh1;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] next_base;
    logic [7:0]        flush_byte;

    assign pclk_rise = pixel_clock & ~pclk_q;
    assign hs_rise   = hsync & ~hs_q;
    assign vs_rise   = vsync & ~vs_q;

    assign pix_ok    = (x_q < X_END) && (y_q < Y_END);
    assign byte_full = {sh_q, pixel_data};

    // Start of the following line; clamped so addr never leaves the bank.
    assign next_base = (y_q >= Y_END - 8'd1) ? ADDR_LAST
                                             : ADDR_W'((int'(y_q) + 1) * LINE_BYTES);

    assign fb.fb_addr  = waddr_q;
    assign fb.fb_data  = data_q;
    assign fb.fb_we    = we_q;
    assign fb.fb_bank  = bank_q;
    assign frame_done  = done_q;
    assign frame_count = cnt_q;
    assign line_err    = lerr_q;
    assign frame_err   = ferr_q;

    // Input edge detectors: one register stage per strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            pclk_q <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            pclk_q <= pixel_clock;
            hs_q   <= hsync;
            vs_q   <= vsync;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            sh_q     <= '0;
            we_q     <= 1'b0;
            data_q   <= '0;
            waddr_q  <= '0;
            bank_q   <= 1'b0;
            toggle_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            lerr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            sh_q     <= sh_d;
            we_q     <= we_d;
            data_q   <= data_d;
            waddr_q  <= waddr_d;
            toggle_q <= toggle_d;
            // The bank flips one cycle after frame_done so that the final
            // flush byte of the frame still lands in the bank it belongs to.
            bank_q   <= bank_q ^ toggle_q;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            lerr_q   <= lerr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic: pixel first, then line/frame end on the same cycle.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        sh_d       = sh_q;
        we_d       = 1'b0;
        data_d     = data_q;
        waddr_d    = waddr_q;
        toggle_d   = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        lerr_d     = lerr_q;
        ferr_d     = ferr_q;
        x1         = x_q;
        sh1        = sh_q;
        addr1      = addr_q;
        flush_byte = 8'h00;

        case (state_q)
            IDLE: begin
                if (vs_rise && capture_en) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    sh_d    = '0;
                end
            end

            CAPTURE: begin
                // Pixel accept / drop.
                if (pclk_rise) begin
                    if (pix_ok) begin
                        sh1 = byte_full[5:0];
                        x1  = x_q + 8'd1;
                        if (x_q[1:0] == 2'd3) begin
                            we_d    = 1'b1;
                            data_d  = byte_full;
                            waddr_d = addr_q;
                            addr1   = (addr_q == ADDR_LAST) ? ADDR_LAST
                                                            : addr_q + ADDR_W'(1);
                        end
                    end else begin
                        lerr_d = 1'b1;
                    end
                end
                x_d    = x1;
                sh_d   = sh1;
                addr_d = addr1;

                // Partial group at line/frame end: left-justify, zero-pad.
                // A group write just above leaves x1 aligned, so at most one
                // write is produced per cycle.
                case (x1[1:0])
                    2'd1:    flush_byte = {sh1[1:0], 6'b0};
                    2'd2:    flush_byte = {sh1[3:0], 4'b0};
                    2'd3:    flush_byte = {sh1[5:0], 2'b0};
                    default: flush_byte = 8'h00;
                endcase
                if ((vs_rise || hs_rise) && (x1[1:0] != 2'd0)) begin
                    we_d    = 1'b1;
                    data_d  = flush_byte;
                    waddr_d = addr1;
                end

                if (vs_rise) begin
                    // Frame end wins over a coincident hsync.
                    done_d   = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                    toggle_d = 1'b1;
                    if (y_q != Y_END)
                        ferr_d = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    sh_d    = '0;
                    state_d = capture_en ? CAPTURE : IDLE;
                end else if (hs_rise) begin
                    if (y_q >= Y_END) begin
                        ferr_d = 1'b1;
                    end else begin
                        if (x1 != X_END)
                            lerr_d = 1'b1;
                        y_d    = y_q + 8'd1;
                        addr_d = next_base;
                    end
                    x_d  = '0;
                    sh_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: drives the pixel stream on the
// falling clock edge, logs framebuffer writes on the falling edge.
module tb_lcd_frame_capture;
    localparam int H  = 160;
    localparam int V  = 144;
    localparam int AW = 13;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       capture_en  = 1'b0;
    logic [1:0] pixel_data  = 2'd0;
    logic       pixel_clock = 1'b0;
    logic       hsync       = 1'b0;
    logic       vsync       = 1'b0;
    logic       frame_done;
    logic [7:0] frame_count;
    logic       line_err;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] wr_addr[$];
    logic [7:0]    wr_data[$];
    logic          wr_bank[$];
    int            done_cnt     = 0;
    int            wr_with_done = 0;

    lcd_frame_capture_if #(.ADDR_W(AW)) fb();

    lcd_frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .capture_en  (capture_en),
        .pixel_data  (pixel_data),
        .pixel_clock (pixel_clock),
        .hsync       (hsync),
        .vsync       (vsync),
        .fb          (fb),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    // Write / frame_done logger.
    always @(negedge clock) begin
        if (fb.fb_we) begin
            wr_addr.push_back(fb.fb_addr);
            wr_data.push_back(fb.fb_data);
            wr_bank.push_back(fb.fb_bank);
            if (frame_done) wr_with_done++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_bank.delete();
        done_cnt     = 0;
        wr_with_done = 0;
    endtask

    task automatic pixel(input logic [1:0] s);
        @(negedge clock);
        pixel_data  = s;
        pixel_clock = 1'b1;
        @(negedge clock);
        pixel_clock = 1'b0;
    endtask

    task automatic pixel_hs(input logic [1:0] s);
        @(negedge clock);
        pixel_data  = s;
        pixel_clock = 1'b1;
        hsync       = 1'b1;
        @(negedge clock);
        pixel_clock = 1'b0;
        hsync       = 1'b0;
    endtask

    task automatic hpulse();
        @(negedge clock);
        hsync = 1'b1;
        @(negedge clock);
        hsync = 1'b0;
    endtask

    task automatic vpulse();
        @(negedge clock);
        vsync = 1'b1;
        @(negedge clock);
        vsync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        capture_en  = 1'b0;
        pixel_clock = 1'b0;
        hsync       = 1'b0;
        vsync       = 1'b0;
        pixel_data  = 2'd0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fb.fb_we, fb.fb_bank, frame_done, line_err, frame_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {fb.fb_we, fb.fb_bank, frame_done, line_err, frame_err});
        end
        checks++;
        if ({frame_count, fb.fb_addr, fb.fb_data} !== '0) begin
            errors++;
            $display("FAIL reset_buses: got cnt=%0d addr=%0d data=%0h want 0",
                     frame_count, fb.fb_addr, fb.fb_data);
        end
    endtask

    task automatic test_full_frame();
        int bad_d, bad_a, bad_b;
        capture_en = 1'b1;
        clear_mon();
        vpulse();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) pixel(2'(x % 4));
            hpulse();
        end
        vpulse();
        tick(4);
        bad_d = 0; bad_a = 0; bad_b = 0;
        foreach (wr_data[i]) begin
            if (wr_data[i] !== 8'h1B)   bad_d++;
            if (wr_addr[i] !== AW'(i))  bad_a++;
            if (wr_bank[i] !== 1'b0)    bad_b++;
        end
        checks++;
        if (wr_data.size() != 5760) begin
            errors++; $display("FAIL full_count: got %0d want 5760", wr_data.size());
        end
        checks++;
        if (bad_d != 0) begin
            errors++; $display("FAIL full_data: got %0d bad bytes want 0", bad_d);
        end
        checks++;
        if (bad_a != 0) begin
            errors++; $display("FAIL full_addr_seq: got %0d bad addrs want 0", bad_a);
        end
        checks++;
        if (bad_b != 0) begin
            errors++; $display("FAIL full_bank: got %0d writes in bank 1 want 0", bad_b);
        end
        checks++;
        if (wr_addr.size() == 0 || wr_addr[$] !== AW'(5759)) begin
            errors++; $display("FAIL full_last_addr: got %0d want 5759",
                               (wr_addr.size() == 0) ? -1 : int'(wr_addr[$]));
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL full_done: got %0d pulses want 1", done_cnt);
        end
        checks++;
        if (frame_count !== 8'd1 || fb.fb_bank !== 1'b1) begin
            errors++; $display("FAIL full_cnt_bank: got cnt=%0d bank=%b want 1/1",
                               frame_count, fb.fb_bank);
        end
        checks++;
        if (line_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL full_errs: got l=%b f=%b want 0/0", line_err, frame_err);
        end
    endtask

    task automatic test_short_line();
        do_reset();
        clear_mon();
        capture_en = 1'b1;
        vpulse();
        repeat (6) pixel(2'd3);
        hpulse();
        repeat (4) pixel(2'd3);
        tick(3);
        checks++;
        if (wr_data.size() != 3) begin
            errors++; $display("FAIL short_count: got %0d want 3", wr_data.size());
        end else begin
            checks++;
            if (wr_data[0] !== 8'hFF || wr_addr[0] !== AW'(0)) begin
                errors++; $display("FAIL short_w0: got %0h@%0d want ff@0", wr_data[0], wr_addr[0]);
            end
            checks++;
            if (wr_data[1] !== 8'hF0 || wr_addr[1] !== AW'(1)) begin
                errors++; $display("FAIL short_w1: got %0h@%0d want f0@1", wr_data[1], wr_addr[1]);
            end
            checks++;
            if (wr_addr[2] !== AW'(40)) begin
                errors++; $display("FAIL short_next_line: got %0d want 40", wr_addr[2]);
            end
        end
        checks++;
        if (line_err !== 1'b1) begin
            errors++; $display("FAIL short_line_err: got %b want 1", line_err);
        end
    endtask

    task automatic test_long_line();
        do_reset();
        clear_mon();
        capture_en = 1'b1;
        vpulse();
        for (int x = 0; x < 163; x++) pixel(2'(x % 4));
        tick(1);
        checks++;
        if (line_err !== 1'b1) begin
            errors++; $display("FAIL long_line_err: got %b want 1", line_err);
        end
        hpulse();
        repeat (4) pixel(2'd3);
        tick(3);
        checks++;
        if (wr_data.size() != 41) begin
            errors++; $display("FAIL long_count: got %0d want 41", wr_data.size());
        end else begin
            checks++;
            if (wr_addr[39] !== AW'(39) || wr_data[39] !== 8'h1B) begin
                errors++; $display("FAIL long_last: got %0h@%0d want 1b@39", wr_data[39], wr_addr[39]);
            end
            checks++;
            if (wr_addr[40] !== AW'(40) || wr_data[40] !== 8'hFF) begin
                errors++; $display("FAIL long_next: got %0h@%0d want ff@40", wr_data[40], wr_addr[40]);
            end
        end
    endtask

    // Continues from the frame left open by test_long_line.
    task automatic test_capture_off();
        clear_mon();
        capture_en = 1'b0;
        vpulse();
        tick(3);
        checks++;
        if (frame_count !== 8'd1 || fb.fb_bank !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL off_close: got cnt=%0d bank=%b done=%0d want 1/1/1",
                               frame_count, fb.fb_bank, done_cnt);
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL off_frame_err: got %b want 1", frame_err);
        end
        clear_mon();
        repeat (8) pixel(2'd2);
        hpulse();
        vpulse();
        repeat (8) pixel(2'd1);
        tick(3);
        checks++;
        if (wr_data.size() != 0 || done_cnt != 0) begin
            errors++; $display("FAIL off_idle: got writes=%0d done=%0d want 0/0",
                               wr_data.size(), done_cnt);
        end
        checks++;
        if (frame_count !== 8'd1) begin
            errors++; $display("FAIL off_count: got %0d want 1", frame_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_mon();
        capture_en = 1'b1;
        vpulse();
        pixel(2'd1);
        pixel(2'd2);
        pixel(2'd3);
        pixel_hs(2'd0);
        tick(2);
        checks++;
        if (wr_data.size() != 1 || wr_data[0] !== 8'h6C || wr_addr[0] !== AW'(0)) begin
            errors++; $display("FAIL coinc_write: got n=%0d first=%0h want n=1 6c@0",
                               wr_data.size(), (wr_data.size() == 0) ? 8'h00 : wr_data[0]);
        end
        repeat (4) pixel(2'd3);
        pixel(2'd2);
        pixel(2'd2);
        capture_en = 1'b0;
        vpulse();
        tick(3);
        checks++;
        if (wr_data.size() != 3) begin
            errors++; $display("FAIL coinc_count: got %0d want 3", wr_data.size());
        end else begin
            checks++;
            if (wr_data[1] !== 8'hFF || wr_addr[1] !== AW'(40)) begin
                errors++; $display("FAIL coinc_next_line: got %0h@%0d want ff@40", wr_data[1], wr_addr[1]);
            end
            checks++;
            if (wr_data[2] !== 8'hA0 || wr_addr[2] !== AW'(41) || wr_bank[2] !== 1'b0) begin
                errors++; $display("FAIL vs_flush: got %0h@%0d bank %b want a0@41 bank 0",
                                   wr_data[2], wr_addr[2], wr_bank[2]);
            end
        end
        checks++;
        if (wr_with_done != 1 || done_cnt != 1) begin
            errors++; $display("FAIL flush_with_done: got %0d/%0d want 1/1", wr_with_done, done_cnt);
        end
        checks++;
        if (frame_err !== 1'b1 || frame_count !== 8'd1) begin
            errors++; $display("FAIL coinc_frame: got ferr=%b cnt=%0d want 1/1", frame_err, frame_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        capture_en = 1'b1;
        vpulse();
        repeat (50) hpulse();
        repeat (4) pixel(2'd1);
        tick(1);
        checks++;
        if (line_err !== 1'b1 || fb.fb_addr !== AW'(2000)) begin
            errors++; $display("FAIL mid_pre: got lerr=%b addr=%0d want 1/2000", line_err, fb.fb_addr);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({fb.fb_we, fb.fb_bank, frame_done, line_err, frame_err, frame_count,
             fb.fb_addr, fb.fb_data} !== '0) begin
            errors++; $display("FAIL mid_reset: got we=%b addr=%0d data=%0h lerr=%b cnt=%0d want 0",
                               fb.fb_we, fb.fb_addr, fb.fb_data, line_err, frame_count);
        end
        reset = 1'b0;
        clear_mon();
        vpulse();
        repeat (2) begin
            repeat (8) pixel(2'd2);
            hpulse();
        end
        vpulse();
        tick(4);
        checks++;
        if (frame_count !== 8'd1 || fb.fb_bank !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL mid_after: got cnt=%0d bank=%b done=%0d want 1/1/1",
                               frame_count, fb.fb_bank, done_cnt);
        end
        checks++;
        if (wr_data.size() != 4 || wr_addr[3] !== AW'(41) || wr_data[3] !== 8'hAA) begin
            errors++; $display("FAIL mid_writes: got n=%0d want 4 ending aa@41", wr_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_line();
        test_long_line();
        test_capture_off();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
